// File: rtl/ataque_grade.sv
// ataque_grade: single-player battleship shot evaluator.
//
// A debounced fire button (botao) is edge-detected. On a press while idle the
// target coordinate (linha, coluna) is latched. The following cycle classifies
// it against the ship matrix (pos) and the shot history. The histories,
// counters and last-shot indicators update on the edge that ends that cycle.
// The game ends on a win (every ship cell hit) or when MAX_TIROS accepted shots
// have been used. It then holds until limpar or reset.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   limpar        synchronous new-game clear (beats botao)
//   botao         fire button level
//   linha/coluna  target row / column
//   pos           ship matrix, bit r*COLS+c is cell (r,c)
//   atq / tiros   hit history / shot history
//   vermelho      last accepted shot missed
//   verde         last accepted shot hit
//   acertos       hit count
//   disparos      accepted shot count
//   invalido      one-cycle pulse for a rejected shot
//   fim           game over
//   vitoria       game won (meaningful only with fim)
//   estado_dbg    current FSM state, for observation only
//
// Handshake: there is no valid/ready pair. A press is accepted only in OCIOSO.
// Presses that arrive while AVALIA or FIM is active are dropped, not queued.
module ataque_grade #(
    parameter int ROWS      = 7,
    parameter int COLS      = 5,
    parameter int MAX_TIROS = 20,
    localparam int N        = ROWS * COLS,
    localparam int RW       = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW       = (COLS > 1) ? $clog2(COLS) : 1,
    localparam int NW       = $clog2(N + 1),
    localparam int TW       = $clog2(MAX_TIROS + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          limpar,
    input  logic          botao,
    input  logic [RW-1:0] linha,
    input  logic [CW-1:0] coluna,
    input  logic [N-1:0]  pos,
    output logic [N-1:0]  atq,
    output logic [N-1:0]  tiros,
    output logic          vermelho,
    output logic          verde,
    output logic [NW-1:0] acertos,
    output logic [TW-1:0] disparos,
    output logic          invalido,
    output logic          fim,
    output logic          vitoria,
    output logic [1:0]    estado_dbg
);

    typedef enum logic [1:0] {
        OCIOSO = 2'd0,
        AVALIA = 2'd1,
        FIM    = 2'd2
    } estado_t;

    estado_t       estado, estado_prox;
    logic          botao_q;
    // Set by reset. A button still held across reset release must be let go
    // before it can fire again.
    logic          bloq;
    logic [RW-1:0] lin_q;
    logic [CW-1:0] col_q;
    logic [NW-1:0] alvo_q;

    logic          press;
    logic [N-1:0]  mascara;
    logic [NW-1:0] alvo_calc;
    logic [NW-1:0] alvo_ef;
    logic          fora, ja_tiro, e_acerto;
    logic [NW-1:0] acertos_n;
    logic [TW-1:0] disparos_n;
    logic          tiro_ok, tiro_rej, vence;

    assign press      = botao && !botao_q && !bloq;
    assign fim        = (estado == FIM);
    assign estado_dbg = estado;

    // One-hot cell select. It stays all-zero when the latched coordinate is
    // off the board, so the out-of-range test needs no separate compare.
    always_comb begin
        mascara = '0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (int'(lin_q) == r && int'(col_q) == c) begin
                    mascara[r*COLS + c] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        alvo_calc = '0;
        for (int i = 0; i < N; i++) begin
            alvo_calc = alvo_calc + NW'(pos[i]);
        end
    end

    assign fora     = (mascara == '0);
    assign ja_tiro  = |(mascara & tiros);
    assign e_acerto = |(mascara & pos);

    // On the first shot the target count is not latched yet, so use the live
    // popcount. The win test on that same shot then sees the right target.
    assign alvo_ef    = (disparos == '0) ? alvo_calc : alvo_q;
    assign acertos_n  = (e_acerto && acertos != NW'(N)) ? acertos + NW'(1) : acertos;
    assign disparos_n = (disparos != TW'(MAX_TIROS)) ? disparos + TW'(1) : disparos;

    always_comb begin
        estado_prox = estado;
        tiro_ok     = 1'b0;
        tiro_rej    = 1'b0;
        vence       = 1'b0;
        case (estado)
            OCIOSO: begin
                if (press) estado_prox = AVALIA;
            end
            AVALIA: begin
                estado_prox = OCIOSO;
                if (fora || ja_tiro) begin
                    tiro_rej = 1'b1;
                end else begin
                    tiro_ok = 1'b1;
                    if (alvo_ef != '0 && acertos_n == alvo_ef) begin
                        estado_prox = FIM;
                        vence       = 1'b1;
                    end else if (disparos_n == TW'(MAX_TIROS)) begin
                        estado_prox = FIM;
                    end
                end
            end
            FIM: begin
                estado_prox = FIM;
            end
            default: begin
                estado_prox = OCIOSO;
            end
        endcase
        if (limpar) begin
            estado_prox = OCIOSO;
            tiro_ok     = 1'b0;
            tiro_rej    = 1'b0;
            vence       = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado <= OCIOSO;
        end else begin
            estado <= estado_prox;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            botao_q  <= 1'b0;
            bloq     <= 1'b1;
            lin_q    <= '0;
            col_q    <= '0;
            alvo_q   <= '0;
            atq      <= '0;
            tiros    <= '0;
            acertos  <= '0;
            disparos <= '0;
            vermelho <= 1'b0;
            verde    <= 1'b0;
            invalido <= 1'b0;
            vitoria  <= 1'b0;
        end else begin
            // Keep tracking the button during limpar too. A held button then
            // does not fire once the clear is done.
            botao_q  <= botao;
            if (!botao) bloq <= 1'b0;
            invalido <= tiro_rej;
            if (limpar) begin
                lin_q    <= '0;
                col_q    <= '0;
                alvo_q   <= '0;
                atq      <= '0;
                tiros    <= '0;
                acertos  <= '0;
                disparos <= '0;
                vermelho <= 1'b0;
                verde    <= 1'b0;
                vitoria  <= 1'b0;
            end else begin
                if (estado == OCIOSO && press) begin
                    lin_q <= linha;
                    col_q <= coluna;
                end
                if (estado == AVALIA && disparos == '0) begin
                    alvo_q <= alvo_calc;
                end
                if (tiro_ok) begin
                    tiros    <= tiros | mascara;
                    disparos <= disparos_n;
                    vitoria  <= vence;
                    if (e_acerto) begin
                        atq      <= atq | mascara;
                        acertos  <= acertos_n;
                        verde    <= 1'b1;
                        vermelho <= 1'b0;
                    end else begin
                        verde    <= 1'b0;
                        vermelho <= 1'b1;
                    end
                end
            end
        end
    end

endmodule
